// File: rtl/ntt_psi_twist_pkg.sv
// ntt_psi_twist_pkg: shared modulus, Barrett constant and psi-power generation for the NTT pre-twist
package ntt_psi_twist_pkg;
  localparam int COEF_K = 27;
  localparam int NTT_LOG_N = 8;
  localparam int NTT_N = 1 << NTT_LOG_N;
  localparam longint unsigned Q = 64'd132120577;
  localparam longint unsigned BARRETT_MU = (64'd1 << (2 * COEF_K)) / Q;
  // 5 is a quadratic non-residue mod Q, so 5^((Q-1)/2N) has order exactly 2N
  localparam longint unsigned NQR = 64'd5;
  function automatic longint unsigned mod_pow(input longint unsigned b, input longint unsigned e);
    longint unsigned r;
    longint unsigned x;
    r = 64'd1;
    x = b % Q;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = r * x % Q;
      x = x * x % Q;
    end
    return r;
  endfunction
  localparam longint unsigned PSI = mod_pow(NQR, (Q - 64'd1) >> (NTT_LOG_N + 1));
endpackage

// File: rtl/barrett_reduction_pipelined.sv
// barrett_reduction_pipelined: r = x mod n for x < n^2, four register stages, data-only (no reset)
module barrett_reduction_pipelined #(
  parameter int K = 27
) (
  input  logic             clk,
  input  logic [2*K-1:0]   x,
  input  logic [K-1:0]     n,
  input  logic [K:0]       mu,
  output logic [K-1:0]     r
);
  localparam int QW = K + 1;
  localparam int RW = K + 2;
  logic [K:0]    q3;
  logic [K+1:0]  x1, x2, qn, r3, n1, n2;
  always_comb begin
    n1 = {2'b00, n};
    n2 = {1'b0, n, 1'b0};
  end
  // remainder estimate lies in [0, 3n), so only the low K+2 bits of x and q*n matter
  always_ff @(posedge clk) begin
    q3 <= QW'(({{QW{1'b0}}, x[2*K-1:K-1]} * {{QW{1'b0}}, mu}) >> QW);
    x1 <= x[K+1:0];
    qn <= RW'({1'b0, q3} * n1);
    x2 <= x1;
    r3 <= x2 - qn;
    r  <= K'(r3 >= n2 ? r3 - n2 : r3 >= n1 ? r3 - n1 : r3);
  end
endmodule

// File: rtl/ntt_psi_twist.sv
// ntt_psi_twist: forward-NTT negacyclic pre-twist, out = a_i * psi^i mod Q
// with a credit-managed output buffer so back-pressure never drops data
module ntt_psi_twist import ntt_psi_twist_pkg::*; #(
  parameter int K = COEF_K,
  parameter int LOG_N = NTT_LOG_N,
  parameter int FIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [K-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [K-1:0] out_data,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready,
  output logic         frame_err
);
  localparam int N = 1 << LOG_N;
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int MW = K + 1;
  localparam int LAT = 6;
  localparam longint unsigned PSI_L = mod_pow(NQR, (Q - 64'd1) >> (LOG_N + 1));
  logic [N-1:0][K-1:0] rom;
  logic [LOG_N-1:0]    idx;
  logic                run, acc, pop, push;
  logic [CW-1:0]       cred, cnt;
  logic [PW-1:0]       wp, rp;
  logic [LAT-1:0]      v, l;
  logic [K-1:0]        a1, tw, red;
  logic [2*K-1:0]      prod;
  logic [K-1:0]        fd [FIFO_DEPTH];
  logic                fl [FIFO_DEPTH];
  for (genvar i = 0; i < N; i++) begin : g_rom
    localparam logic [K-1:0] P = K'(mod_pow(PSI_L, longint'(i)));
    assign rom[i] = P;
  end
  assign acc = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign push = v[LAT-1];
  // credits cover everything accepted but not yet handed out, so the buffer cannot overflow
  assign in_ready = run && (cred < CW'(FIFO_DEPTH));
  assign out_valid = cnt != '0;
  assign out_data = out_valid ? fd[rp] : '0;
  assign out_last = out_valid && fl[rp];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
      idx <= '0;
      cred <= '0;
      cnt <= '0;
      wp <= '0;
      rp <= '0;
      v <= '0;
      frame_err <= 1'b0;
    end else begin
      run <= 1'b1;
      if (acc) idx <= idx + LOG_N'(1);
      cred <= cred + CW'(acc) - CW'(pop);
      cnt <= cnt + CW'(push) - CW'(pop);
      if (push) wp <= (wp == PW'(FIFO_DEPTH - 1)) ? '0 : wp + PW'(1);
      if (pop) rp <= (rp == PW'(FIFO_DEPTH - 1)) ? '0 : rp + PW'(1);
      v <= {v[LAT-2:0], acc};
      frame_err <= acc && (in_last != (&idx));
    end
  end
  always_ff @(posedge clk) begin
    if (acc) begin
      a1 <= in_data;
      tw <= rom[idx];
    end
    prod <= {{K{1'b0}}, a1} * {{K{1'b0}}, tw};
    l <= {l[LAT-2:0], &idx};
    if (push) begin
      fd[wp] <= red;
      fl[wp] <= l[LAT-1];
    end
  end
  barrett_reduction_pipelined #(.K(K)) u_barrett (
    .clk (clk),
    .x   (prod),
    .n   (K'(Q)),
    .mu  (MW'(BARRETT_MU)),
    .r   (red)
  );
endmodule
